// File: rtl/parity_err_monitor.sv
// Parity error monitor: debounces upstream parity failures into an alarm with hysteresis.
// Optional sticky failure flag enabled by defining PARITY_MON_STICKY_EN.
module parity_err_monitor #(
  parameter int unsigned THRESH  = 3,
  parameter int unsigned RECOVER = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             parity_in,
  input  logic             clr,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       consec_cnt,
  output logic             alarm,
  output logic             alarm_pulse,
  output logic             sticky_err
);

  typedef enum logic [1:0] {
    S_OK      = 2'd0,
    S_SUSPECT = 2'd1,
    S_ALARM   = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  localparam logic [3:0] THRESH_C  = 4'(THRESH);
  localparam logic [3:0] RECOVER_C = 4'(RECOVER);

  state_t           state, state_next;
  logic [3:0]       good_run, good_next, consec_next;
  logic [CNT_W-1:0] err_next;
  logic             alarm_next, pulse_next;
  logic             fail, good;

  assign fail = in_valid & parity_in;
  assign good = in_valid & ~parity_in;

  // State and counter registers; clr drops any same-cycle sample.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state       <= S_OK;
      good_run    <= '0;
      consec_cnt  <= '0;
      err_cnt     <= '0;
      alarm       <= 1'b0;
      alarm_pulse <= 1'b0;
    end else begin
      state       <= state_next;
      good_run    <= good_next;
      consec_cnt  <= consec_next;
      err_cnt     <= err_next;
      alarm       <= alarm_next;
      alarm_pulse <= pulse_next;
    end
  end

  always_comb begin
    state_next  = state;
    consec_next = consec_cnt;
    good_next   = good_run;
    case (state)
      S_OK: begin
        if (fail) begin
          consec_next = 4'd1;
          state_next  = (THRESH_C == 4'd1) ? S_ALARM : S_SUSPECT;
        end
      end
      S_SUSPECT: begin
        if (fail) begin
          consec_next = consec_cnt + 4'd1;
          if (consec_cnt + 4'd1 == THRESH_C) state_next = S_ALARM;
        end else if (good) begin
          consec_next = '0;
          state_next  = S_OK;
        end
      end
      S_ALARM: begin
        if (good) begin
          consec_next = '0;
          if (RECOVER_C == 4'd1) begin
            good_next  = '0;
            state_next = S_OK;
          end else begin
            good_next  = 4'd1;
            state_next = S_RECOVER;
          end
        end else if (fail) begin
          if (consec_cnt != 4'hF) consec_next = consec_cnt + 4'd1;
        end
      end
      S_RECOVER: begin
        if (good) begin
          if (good_run + 4'd1 == RECOVER_C) begin
            good_next  = '0;
            state_next = S_OK;
          end else begin
            good_next = good_run + 4'd1;
          end
        end else if (fail) begin
          good_next   = '0;
          consec_next = 4'd1;
          state_next  = S_ALARM;
        end
      end
      default: state_next = S_OK;
    endcase
  end

  // Outputs are decoded from the next state so they land in registers.
  always_comb begin
    err_next   = (fail && (err_cnt != '1)) ? err_cnt + CNT_W'(1) : err_cnt;
    alarm_next = (state_next == S_ALARM) || (state_next == S_RECOVER);
    pulse_next = ((state == S_OK) || (state == S_SUSPECT)) && (state_next == S_ALARM);
  end

`ifdef PARITY_MON_STICKY_EN
  always_ff @(posedge clk) begin
    if (rst || clr) sticky_err <= 1'b0;
    else if (fail)  sticky_err <= 1'b1;
  end
`else
  assign sticky_err = 1'b0;
`endif

endmodule

// File: tb/tb_parity_err_monitor.sv
// Directed bench for parity_err_monitor: default instance plus a THRESH=1/RECOVER=1/CNT_W=4 instance.
module tb_parity_err_monitor;

`ifdef PARITY_MON_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 1'b0, a_par = 1'b0, a_clr = 1'b0;
  logic       b_valid = 1'b0, b_par = 1'b0, b_clr = 1'b0;
  logic [7:0] a_err;
  logic [3:0] a_consec, b_err, b_consec;
  logic       a_alarm, a_pulse, a_sticky;
  logic       b_alarm, b_pulse, b_sticky;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  parity_err_monitor #(.THRESH(3), .RECOVER(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(a_valid), .parity_in(a_par), .clr(a_clr),
    .err_cnt(a_err), .consec_cnt(a_consec), .alarm(a_alarm),
    .alarm_pulse(a_pulse), .sticky_err(a_sticky)
  );

  parity_err_monitor #(.THRESH(1), .RECOVER(1), .CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .parity_in(b_par), .clr(b_clr),
    .err_cnt(b_err), .consec_cnt(b_consec), .alarm(b_alarm),
    .alarm_pulse(b_pulse), .sticky_err(b_sticky)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock on instance A; outputs are sampled 1 time unit after the edge.
  task automatic step_a(input logic v, input logic p, input logic c);
    a_valid = v; a_par = p; a_clr = c;
    @(posedge clk); #1;
    a_valid = 1'b0; a_par = 1'b0; a_clr = 1'b0;
  endtask

  task automatic step_b(input logic v, input logic p);
    b_valid = v; b_par = p;
    @(posedge clk); #1;
    b_valid = 1'b0; b_par = 1'b0;
  endtask

  task automatic chk_a(input string tag, input int unsigned err, input int unsigned consec,
                       input int unsigned alm, input int unsigned pls, input int unsigned stk);
    chk({tag, ".err"},    a_err,    err);
    chk({tag, ".consec"}, a_consec, consec);
    chk({tag, ".alarm"},  a_alarm,  alm);
    chk({tag, ".pulse"},  a_pulse,  pls);
    chk({tag, ".sticky"}, a_sticky, STICKY ? stk : 0);
  endtask

  initial begin
    // Reset for two cycles
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_a("reset", 0, 0, 0, 0, 0);
    chk("reset.b_err", b_err, 0);
    chk("reset.b_alarm", b_alarm, 0);

    // Five good samples keep everything idle
    for (int i = 0; i < 5; i++) step_a(1, 0, 0);
    chk_a("good5", 0, 0, 0, 0, 0);

    // fail,fail,good,fail,fail,fail
    step_a(1, 1, 0); chk_a("seq1", 1, 1, 0, 0, 1);
    step_a(1, 1, 0); chk_a("seq2", 2, 2, 0, 0, 1);
    step_a(1, 0, 0); chk_a("seq3", 2, 0, 0, 0, 1);
    step_a(1, 1, 0); chk_a("seq4", 3, 1, 0, 0, 1);
    step_a(1, 1, 0); chk_a("seq5", 4, 2, 0, 0, 1);
    step_a(1, 1, 0); chk_a("seq6", 5, 3, 1, 1, 1);
    step_a(0, 0, 0); chk_a("pulse_end", 5, 3, 1, 0, 1);

    // Recovery with a relapse: good x3, fail, good x4
    step_a(1, 0, 0); chk_a("rec_g1", 5, 0, 1, 0, 1);
    step_a(1, 0, 0); chk_a("rec_g2", 5, 0, 1, 0, 1);
    step_a(1, 0, 0); chk_a("rec_g3", 5, 0, 1, 0, 1);
    step_a(1, 1, 0); chk_a("rec_f",  6, 1, 1, 0, 1);
    step_a(1, 0, 0); chk_a("rec_g4", 6, 0, 1, 0, 1);
    step_a(1, 0, 0); chk_a("rec_g5", 6, 0, 1, 0, 1);
    step_a(1, 0, 0); chk_a("rec_g6", 6, 0, 1, 0, 1);
    step_a(1, 0, 0); chk_a("rec_g7", 6, 0, 0, 0, 1);

    // Back in OK: invalid samples are ignored
    step_a(0, 1, 0); chk_a("idle_inv", 6, 0, 0, 0, 1);

    // Re-enter ALARM, then clr with a same-cycle failure
    step_a(1, 1, 0); step_a(1, 1, 0); step_a(1, 1, 0);
    chk_a("alarm2", 9, 3, 1, 1, 1);
    step_a(1, 1, 0); chk_a("alarm2_f", 10, 4, 1, 0, 1);
    step_a(1, 1, 1); chk_a("clr", 0, 0, 0, 0, 0);

    // Suspect state holds across an invalid cycle
    step_a(1, 1, 0); chk_a("susp", 1, 1, 0, 0, 1);
    step_a(0, 1, 0); chk_a("susp_hold", 1, 1, 0, 0, 1);
    step_a(1, 1, 0); step_a(1, 1, 0);
    chk_a("alarm3", 3, 3, 1, 1, 1);

    // Reset during alarm, with a failed sample present
    rst = 1'b1;
    step_a(1, 1, 0);
    rst = 1'b0;
    chk_a("rst_mid", 0, 0, 0, 0, 0);

    // Instance B: THRESH=1 alarms on first failure, RECOVER=1 clears on first good
    step_b(1, 1);
    chk("b1.alarm", b_alarm, 1); chk("b1.pulse", b_pulse, 1);
    chk("b1.consec", b_consec, 1); chk("b1.err", b_err, 1);
    step_b(1, 0);
    chk("b2.alarm", b_alarm, 0); chk("b2.consec", b_consec, 0);
    for (int i = 0; i < 19; i++) step_b(1, 1);
    chk("bsat.err", b_err, 15); chk("bsat.consec", b_consec, 15);
    chk("bsat.alarm", b_alarm, 1); chk("bsat.pulse", b_pulse, 0);
    chk("bsat.sticky", b_sticky, STICKY ? 1 : 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/parity_err_monitor.md
PARITY_ERR_MONITOR -- requirements
Module: parity_err_monitor

Interface
REQ-001 SHALL have parameter THRESH, default 3: consecutive failed samples that raise the alarm (legal 1..15).
REQ-002 SHALL have parameter RECOVER, default 4: consecutive good samples that clear the alarm (legal 1..15).
REQ-003 SHALL have parameter CNT_W, default 8: width of the total error counter.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  parity_in is a sample this cycle.
REQ-007 SHALL have port parity_in  input  1  upstream parity_check result; 1 = check failed, 0 = good.
REQ-008 SHALL have port clr  input  1  synchronous clear of state and counters.
REQ-009 SHALL have port err_cnt  output  CNT_W  total failed samples, saturating.
REQ-010 SHALL have port consec_cnt  output  4  current run of consecutive failed samples.
REQ-011 SHALL have port alarm  output  1  high in states ALARM and RECOVER.
REQ-012 SHALL have port alarm_pulse  output  1  one-cycle strobe on alarm assertion.
REQ-013 SHALL have port sticky_err  output  1  any failure seen since reset/clr (see Configuration).

Function
REQ-014 SHALL register all outputs; a sample at edge N is reflected in the outputs after edge N.
REQ-015 SHALL ignore parity_in when in_valid=0; state and counters hold.
REQ-016 SHALL implement states OK, SUSPECT, ALARM, RECOVER.
REQ-017 OK: failed sample -> consec_cnt=1; go to ALARM if THRESH=1, else to SUSPECT; good sample -> stay.
REQ-018 SUSPECT: failed sample -> consec_cnt+1; go to ALARM when the new value equals THRESH; good sample -> consec_cnt=0, go to OK.
REQ-019 ALARM: good sample -> consec_cnt=0, good run=1; go to OK if RECOVER=1, else to RECOVER; failed sample -> stay, consec_cnt+1 saturating at 15.
REQ-020 RECOVER: good sample -> good run+1; go to OK when it equals RECOVER; failed sample -> good run=0, consec_cnt=1, go to ALARM.
REQ-021 alarm_pulse SHALL be 1 for exactly the cycle after a transition OK/SUSPECT -> ALARM; no pulse on RECOVER -> ALARM.
REQ-022 err_cnt SHALL increment on every failed valid sample and saturate at 2^CNT_W-1 without wrapping.
REQ-023 clr SHALL take priority over a same-cycle sample: the sample is dropped, state -> OK, all counters and outputs -> 0.
REQ-024 The internal good-run counter SHALL not be an output; it is 0 in OK and SUSPECT.

Reset
REQ-025 On rst=1 at a clock edge: state=OK, err_cnt=0, consec_cnt=0, alarm=0, alarm_pulse=0, sticky_err=0.
REQ-026 rst SHALL take priority over clr and in_valid; reset mid-alarm returns to OK with no alarm_pulse.

Configuration
REQ-027 Macro PARITY_MON_STICKY_EN SHALL control the sticky flag.
REQ-028 With PARITY_MON_STICKY_EN defined: sticky_err is set one cycle after any failed valid sample and is cleared only by rst or clr.
REQ-029 Without PARITY_MON_STICKY_EN: the sticky_err port exists and is driven constant 0; all other behaviour is identical.

Verification
REQ-030 rst 2 cycles, then 5 good valid samples -> state OK, err_cnt=0, alarm=0.
REQ-031 THRESH=3: samples fail,fail,good,fail,fail,fail -> alarm rises after the 6th sample, alarm_pulse high for one cycle, err_cnt=5, consec_cnt=3.
REQ-032 In ALARM with RECOVER=4: samples good x3, fail, good x4 -> alarm stays 1 throughout the first 8 samples, no second alarm_pulse, drops after the 8th sample.
REQ-033 CNT_W=4: 20 failed samples -> err_cnt holds at 15; consec_cnt holds at 15.
REQ-034 clr asserted together with a failed valid sample while in ALARM -> next cycle all outputs 0 and err_cnt stays 0 (sample dropped).
REQ-035 With PARITY_MON_STICKY_EN: a single failed sample among good samples -> sticky_err=1 and remains 1 after returning to OK, cleared by clr.
